// File: rtl/wb_csr_ctrl_pkg.sv
// wb_csr_ctrl_pkg: CSR op encodings, WB FSM states and CSR numbers shared with the CSR file
package wb_csr_ctrl_pkg;
  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RD   = 2'b01,
    CSR_WR   = 2'b10,
    CSR_XCHG = 2'b11
  } csr_op_e;
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_REDIR = 1'b1
  } wb_state_e;
  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;
endpackage

// File: rtl/wb_csr_ctrl.sv
// wb_csr_ctrl: WB-stage CSR access, exception/ertn commit and pipeline redirect control
module wb_csr_ctrl
  import wb_csr_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic [1:0]  ws_csr_op,
  input  logic [13:0] ws_csr_num,
  input  logic [31:0] ws_rd_value,
  input  logic [31:0] ws_rj_value,
  input  logic        ws_ertn,
  input  logic        ws_ex,
  input  logic [5:0]  ws_ecode,
  input  logic [8:0]  ws_esubcode,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_entry,
  input  logic [31:0] csr_rvalue,
  input  logic        br_ready,
  output logic        csr_re,
  output logic [13:0] csr_num,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic        ertn_flush,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  output logic        flush_req,
  output logic        br_valid,
  output logic [31:0] br_target,
  output logic        ws_allowin
);
  wb_state_e   state, state_nx;
  logic [31:0] tgt, tgt_nx;
  logic        idle, redir, live, ex, er, csr, wr;
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      tgt   <= '0;
    end else begin
      state <= state_nx;
      tgt   <= tgt_nx;
    end
  // Outputs are gated by reset so they read as idle before the first edge
  always_comb begin
    idle        = !reset && state == S_IDLE;
    redir       = !reset && state == S_REDIR;
    live        = idle && ws_valid;
    ex          = live && ws_ex;
    er          = live && ws_ertn && !ws_ex;
    csr         = live && !ws_ex && !ws_ertn && ws_csr_op != CSR_NONE;
    wr          = csr && (ws_csr_op == CSR_WR || ws_csr_op == CSR_XCHG);
    state_nx    = (ex || er) ? S_REDIR : (redir && br_ready) ? S_IDLE : state;
    tgt_nx      = ex ? ex_entry : er ? ertn_entry : tgt;
    csr_re      = csr;
    csr_num     = (!reset && ws_csr_op != CSR_NONE) ? ws_csr_num : '0;
    csr_we      = wr;
    csr_wmask   = !wr ? '0 : ws_csr_op == CSR_WR ? 32'hffff_ffff : ws_rj_value;
    csr_wvalue  = wr ? ws_rd_value : '0;
    rf_we       = csr;
    rf_wdata    = csr ? csr_rvalue : '0;
    wb_ex       = ex;
    wb_ecode    = ex ? ws_ecode : '0;
    wb_esubcode = ex ? ws_esubcode : '0;
    wb_pc       = ex ? ws_pc : '0;
    ertn_flush  = er;
    flush_req   = redir;
    br_valid    = redir;
    br_target   = redir ? tgt : '0;
    ws_allowin  = !redir;
  end
endmodule

// File: tb/tb_wb_csr_ctrl.sv
// tb_wb_csr_ctrl: directed and random checks of wb_csr_ctrl against a behavioural model
module tb_wb_csr_ctrl;
  logic        clk = 0, reset = 1;
  logic        ws_valid = 0, ws_ertn = 0, ws_ex = 0, br_ready = 0;
  logic [31:0] ws_pc = 0, ws_rd_value = 0, ws_rj_value = 0, ex_entry = 0, ertn_entry = 0, csr_rvalue = 0;
  logic [1:0]  ws_csr_op = 0;
  logic [13:0] ws_csr_num = 0;
  logic [5:0]  ws_ecode = 0;
  logic [8:0]  ws_esubcode = 0;
  logic        csr_re, csr_we, wb_ex, ertn_flush, rf_we, flush_req, br_valid, ws_allowin;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue, wb_pc, rf_wdata, br_target;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  int checks = 0, errors = 0;
  bit m_redir = 0;
  logic [31:0] m_tgt = 0;

  wb_csr_ctrl dut (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_csr_op(ws_csr_op),
    .ws_csr_num(ws_csr_num), .ws_rd_value(ws_rd_value), .ws_rj_value(ws_rj_value),
    .ws_ertn(ws_ertn), .ws_ex(ws_ex), .ws_ecode(ws_ecode), .ws_esubcode(ws_esubcode),
    .ex_entry(ex_entry), .ertn_entry(ertn_entry), .csr_rvalue(csr_rvalue), .br_ready(br_ready),
    .csr_re(csr_re), .csr_num(csr_num), .csr_we(csr_we), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .ertn_flush(ertn_flush), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .flush_req(flush_req), .br_valid(br_valid), .br_target(br_target), .ws_allowin(ws_allowin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: what each output should be given the commit rules and the redirect flag
  task automatic compare_model();
    bit act, is_ex, is_er, is_csr, is_wr;
    act    = !reset && !m_redir && ws_valid;
    is_ex  = act && ws_ex;
    is_er  = act && !ws_ex && ws_ertn;
    is_csr = act && !ws_ex && !ws_ertn && ws_csr_op != 2'd0;
    is_wr  = is_csr && ws_csr_op[1];
    chk("m_csr_re", csr_re, is_csr);
    chk("m_csr_num", csr_num, (!reset && ws_csr_op != 2'd0) ? ws_csr_num : 0);
    chk("m_csr_we", csr_we, is_wr);
    chk("m_wmask", csr_wmask, !is_wr ? 0 : ws_csr_op == 2'd2 ? 32'hffffffff : ws_rj_value);
    chk("m_wvalue", csr_wvalue, is_wr ? ws_rd_value : 0);
    chk("m_rf_we", rf_we, is_csr);
    chk("m_rf_wdata", rf_wdata, is_csr ? csr_rvalue : 0);
    chk("m_wb_ex", wb_ex, is_ex);
    chk("m_ecode", wb_ecode, is_ex ? ws_ecode : 0);
    chk("m_esub", wb_esubcode, is_ex ? ws_esubcode : 0);
    chk("m_wb_pc", wb_pc, is_ex ? ws_pc : 0);
    chk("m_ertn", ertn_flush, is_er);
    chk("m_flush", flush_req, m_redir && !reset);
    chk("m_br_valid", br_valid, m_redir && !reset);
    chk("m_br_target", br_target, (m_redir && !reset) ? m_tgt : 0);
    chk("m_allowin", ws_allowin, !m_redir || reset);
  endtask

  task automatic cyc();
    bit act;
    #1 compare_model();
    @(posedge clk);
    act = !m_redir && ws_valid && (ws_ex || ws_ertn);
    if (reset) begin
      m_redir = 0;
      m_tgt = 0;
    end else if (m_redir) begin
      if (br_ready) m_redir = 0;
    end else if (act) begin
      m_redir = 1;
      m_tgt = ws_ex ? ex_entry : ertn_entry;
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cyc();
    cyc();
    reset = 0;
    ws_valid = 1; ws_csr_op = 2'd2; ws_csr_num = 14'h30; ws_rd_value = 32'h12345678; csr_rvalue = 32'hA;
    #1;
    chk("wr_we", csr_we, 1);
    chk("wr_mask", csr_wmask, 32'hffffffff);
    chk("wr_value", csr_wvalue, 32'h12345678);
    chk("wr_rdata", rf_wdata, 32'hA);
    chk("wr_num", csr_num, 14'h30);
    cyc();
    ws_csr_op = 2'd3; ws_rj_value = 32'h0000FF00; ws_rd_value = 32'hDEADBEEF;
    #1;
    chk("xchg_mask", csr_wmask, 32'h0000FF00);
    chk("xchg_value", csr_wvalue, 32'hDEADBEEF);
    chk("xchg_rf_we", rf_we, 1);
    cyc();
    ws_csr_op = 2'd0; ws_ex = 1; ws_ecode = 6'h0B; ws_esubcode = 9'h1; ws_pc = 32'h1C000100;
    ex_entry = 32'h1C008000; ertn_entry = 32'h1C000200;
    #1;
    chk("ex_pulse", wb_ex, 1);
    chk("ex_pc", wb_pc, 32'h1C000100);
    chk("ex_ecode", wb_ecode, 6'h0B);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("redir_valid", br_valid, 1);
      chk("redir_flush", flush_req, 1);
      chk("redir_target", br_target, 32'h1C008000);
      chk("redir_no_ex", wb_ex, 0);
      chk("redir_allowin", ws_allowin, 0);
      cyc();
    end
    br_ready = 1;
    #1 chk("ready_valid", br_valid, 1);
    cyc();
    ws_valid = 0; ws_ex = 0; br_ready = 0;
    #1;
    chk("back_idle_valid", br_valid, 0);
    chk("back_idle_allowin", ws_allowin, 1);
    cyc();
    ws_valid = 1; ws_ex = 1; ws_ertn = 1; ws_csr_op = 2'd2;
    #1;
    chk("prio_ex", wb_ex, 1);
    chk("prio_ertn", ertn_flush, 0);
    chk("prio_csr_we", csr_we, 0);
    chk("prio_rf_we", rf_we, 0);
    cyc();
    ws_valid = 0; ws_ex = 0; ws_ertn = 0; ws_csr_op = 2'd0; br_ready = 1;
    cyc();
    br_ready = 0; ws_valid = 1; ws_ertn = 1;
    #1 chk("ertn_pulse", ertn_flush, 1);
    cyc();
    ws_valid = 0; ws_ertn = 0;
    #1;
    chk("ertn_target", br_target, 32'h1C000200);
    chk("ertn_once", ertn_flush, 0);
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    #1;
    chk("rst_redir_valid", br_valid, 0);
    chk("rst_redir_allowin", ws_allowin, 1);
    cyc();
    for (int i = 0; i < 3000; i++) begin
      reset       = $urandom_range(0, 99) < 2;
      ws_valid    = $urandom_range(0, 9) < 7;
      ws_ex       = $urandom_range(0, 99) < 15;
      ws_ertn     = $urandom_range(0, 99) < 15;
      br_ready    = $urandom_range(0, 1);
      ws_csr_op   = 2'($urandom);
      ws_csr_num  = 14'($urandom);
      ws_pc       = $urandom;
      ws_rd_value = $urandom;
      ws_rj_value = $urandom;
      ws_ecode    = 6'($urandom);
      ws_esubcode = 9'($urandom);
      ex_entry    = $urandom;
      ertn_entry  = $urandom;
      csr_rvalue  = $urandom;
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
